seg_write_arb: RTL and testbench
================================

SEG_WRITE_ARB -- requirements
Module: seg_write_arb

Interface
REQ-001 SHALL have parameter INHIBIT_CNT, default 1: number of INSTR_DONE pulses for which interrupts stay inhibited after an SS write (range 1..3).
REQ-002 SHALL have port CLK, input, 1: single clock, rising-edge.
REQ-003 SHALL have port RST, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have ports REQA_VALID input 1, REQA_SEG input 2, REQA_DATA input 16, REQA_READY output 1: execution-unit request (MOV/POP seg).
REQ-005 SHALL have ports REQB_VALID input 1, REQB_SEG input 2, REQB_DATA input 16, REQB_LOCK input 1, REQB_READY output 1: far-load/interrupt-sequencer request.
REQ-006 SHALL have port INSTR_DONE, input, 1: one-cycle pulse at each instruction boundary.
REQ-007 SHALL have ports ENA_ES, ENA_CS, ENA_SS, ENA_DS, output, 1 each: enables to the four segment registers.
REQ-008 SHALL have port D_SEG, output, 16: shared data bus to the segment registers.
REQ-009 SHALL have ports FLUSH_Q output 1 (prefetch-queue flush) and INT_INHIBIT output 1.

Function
REQ-010 SHALL encode SEG as 00=ES, 01=CS, 10=SS, 11=DS.
REQ-011 SHALL implement states IDLE, WRITE, LOCKED.
REQ-012 Handshake SHALL occur in a cycle where VALID and READY are both high; READY SHALL depend only on state, last-grant bit and the two VALID inputs.
REQ-013 IDLE: one requester valid -> that requester's READY high; both valid -> grant the requester not granted last (round-robin); neither -> both READY low.
REQ-014 LOCKED: only REQB_READY may be high (equal to REQB_VALID); REQA_READY SHALL be low.
REQ-015 On handshake the block SHALL go to WRITE and register the granted SEG/DATA; in WRITE exactly one ENA_x SHALL be high for one cycle and D_SEG SHALL carry the data (latency: enable one cycle after handshake).
REQ-016 WRITE -> LOCKED if the write came from B with REQB_LOCK high at handshake; else WRITE -> IDLE.
REQ-017 LOCKED -> on B handshake go to WRITE; if REQB_LOCK low at that handshake, lock is released after that write.
REQ-018 Both READY outputs SHALL be low in WRITE; maximum throughput is one write per two cycles.
REQ-019 FLUSH_Q SHALL pulse high in the same cycle as ENA_CS.
REQ-020 A write to SS SHALL load the inhibit counter with INHIBIT_CNT in the ENA_SS cycle; INT_INHIBIT SHALL be high whenever counter is non-zero; each INSTR_DONE decrements it, saturating at 0.
REQ-021 INSTR_DONE coinciding with ENA_SS SHALL be ignored (reload wins); a second SS write reloads the counter.
REQ-022 D_SEG SHALL hold its last value when no ENA_x is high.
REQ-023 Last-grant bit SHALL update on every handshake.

Reset
REQ-024 On RST: state IDLE, all ENA_x 0, FLUSH_Q 0, D_SEG 0x0000, inhibit counter 0 (INT_INHIBIT 0), last-grant = B (A wins first tie), lock cleared.
REQ-025 RST asserted in WRITE or LOCKED SHALL abort with no enable issued in the following cycle.

Structure
REQ-026 SEG encodings and state encodings SHALL live in the shared processor package.
REQ-027 The inhibit counter SHALL be a sub-module seg_inhibit_cnt; arbitration and FSM stay in the top module.

Verification
REQ-028 A only, SEG=11 DATA=0x1234 -> READY_A same cycle, ENA_DS=1 and D_SEG=0x1234 next cycle, others 0.
REQ-029 A and B both valid from reset (A: ES 0x1111, B: DS 0x2222) -> A granted first (ENA_ES), B on next handshake (ENA_DS) two cycles later.
REQ-030 B writes CS 0xF000 with LOCK=1 then SS 0x0300 with LOCK=0 while A valid -> A stalled until both B writes done; FLUSH_Q with ENA_CS.
REQ-031 SS write with INHIBIT_CNT=1 -> INT_INHIBIT high from ENA_SS cycle until one cycle after first INSTR_DONE; INSTR_DONE coincident with ENA_SS does not clear it.
REQ-032 RST in WRITE state -> no ENA_x next cycle, outputs at reset values, A served normally afterwards.

Source files
------------

// File: rtl/seg_write_arb_pkg.sv
// Shared processor definitions: segment-register encodings and the write arbiter states.
package seg_write_arb_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned SEG_W  = 2;
    localparam int unsigned INH_W  = 2;

    typedef enum logic [SEG_W-1:0] {
        SEG_ES = 2'b00,
        SEG_CS = 2'b01,
        SEG_SS = 2'b10,
        SEG_DS = 2'b11
    } seg_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_WRITE  = 2'b01,
        ST_LOCKED = 2'b10
    } state_e;

endpackage

// File: rtl/seg_inhibit_cnt.sv
// Interrupt-inhibit window after an SS write, counted in instruction boundaries.
module seg_inhibit_cnt
    import seg_write_arb_pkg::*;
#(
    parameter int unsigned INHIBIT_CNT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic inhibit
);

    logic [INH_W-1:0] cnt;

    // A reload always wins over a decrement in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= INH_W'(INHIBIT_CNT);
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - INH_W'(1);
        end
    end

    assign inhibit = (cnt != '0);

endmodule

// File: rtl/seg_write_arb.sv
// Round-robin arbiter between execution-unit and sequencer segment-register writes,
// with bus locking for far loads and an SS interrupt-inhibit window.
module seg_write_arb
    import seg_write_arb_pkg::*;
#(
    parameter int unsigned INHIBIT_CNT = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQA_VALID,
    input  logic [SEG_W-1:0]  REQA_SEG,
    input  logic [DATA_W-1:0] REQA_DATA,
    output logic              REQA_READY,
    input  logic              REQB_VALID,
    input  logic [SEG_W-1:0]  REQB_SEG,
    input  logic [DATA_W-1:0] REQB_DATA,
    input  logic              REQB_LOCK,
    output logic              REQB_READY,
    input  logic              INSTR_DONE,
    output logic              ENA_ES,
    output logic              ENA_CS,
    output logic              ENA_SS,
    output logic              ENA_DS,
    output logic [DATA_W-1:0] D_SEG,
    output logic              FLUSH_Q,
    output logic              INT_INHIBIT
);

    state_e            state;
    logic              last_b;
    logic              lock_q;
    logic [3:0]        ena_q;
    logic              grant_a;
    logic              grant_b;
    logic              hs;
    seg_e              hs_seg;
    logic [DATA_W-1:0] hs_data;

    // Grants depend only on state, last grant and the two valids.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        case (state)
            ST_IDLE: begin
                if (REQA_VALID && (!REQB_VALID || last_b)) begin
                    grant_a = 1'b1;
                end else begin
                    grant_b = REQB_VALID;
                end
            end
            ST_LOCKED: grant_b = REQB_VALID;
            default: begin
                grant_a = 1'b0;
                grant_b = 1'b0;
            end
        endcase
    end

    assign REQA_READY = grant_a;
    assign REQB_READY = grant_b;
    assign hs         = grant_a | grant_b;
    assign hs_seg     = seg_e'(grant_a ? REQA_SEG : REQB_SEG);
    assign hs_data    = grant_a ? REQA_DATA : REQB_DATA;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= ST_IDLE;
            last_b  <= 1'b1;
            lock_q  <= 1'b0;
            ena_q   <= '0;
            FLUSH_Q <= 1'b0;
            D_SEG   <= '0;
        end else begin
            ena_q   <= '0;
            FLUSH_Q <= 1'b0;
            case (state)
                ST_IDLE, ST_LOCKED: begin
                    if (hs) begin
                        state   <= ST_WRITE;
                        D_SEG   <= hs_data;
                        ena_q   <= 4'(4'b0001 << hs_seg);
                        FLUSH_Q <= (hs_seg == SEG_CS);
                        last_b  <= grant_b;
                        lock_q  <= grant_b & REQB_LOCK;
                    end
                end
                ST_WRITE: state <= lock_q ? ST_LOCKED : ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    assign ENA_ES = ena_q[0];
    assign ENA_CS = ena_q[1];
    assign ENA_SS = ena_q[2];
    assign ENA_DS = ena_q[3];

    seg_inhibit_cnt #(
        .INHIBIT_CNT(INHIBIT_CNT)
    ) u_inhibit (
        .clk     (CLK),
        .rst     (RST),
        .load    (hs && (hs_seg == SEG_SS)),
        .dec     (INSTR_DONE && !ENA_SS),
        .inhibit (INT_INHIBIT)
    );

endmodule

// File: tb/tb_seg_write_arb.sv
// Randomized check of seg_write_arb against a transaction-level model, plus directed scenarios.
module tb_seg_write_arb;

    localparam int unsigned INH = 1;

    logic        CLK;
    logic        RST;
    logic        REQA_VALID;
    logic [1:0]  REQA_SEG;
    logic [15:0] REQA_DATA;
    logic        REQA_READY;
    logic        REQB_VALID;
    logic [1:0]  REQB_SEG;
    logic [15:0] REQB_DATA;
    logic        REQB_LOCK;
    logic        REQB_READY;
    logic        INSTR_DONE;
    logic        ENA_ES, ENA_CS, ENA_SS, ENA_DS;
    logic [15:0] D_SEG;
    logic        FLUSH_Q;
    logic        INT_INHIBIT;

    seg_write_arb #(.INHIBIT_CNT(INH)) dut (
        .CLK(CLK), .RST(RST),
        .REQA_VALID(REQA_VALID), .REQA_SEG(REQA_SEG), .REQA_DATA(REQA_DATA), .REQA_READY(REQA_READY),
        .REQB_VALID(REQB_VALID), .REQB_SEG(REQB_SEG), .REQB_DATA(REQB_DATA), .REQB_LOCK(REQB_LOCK),
        .REQB_READY(REQB_READY), .INSTR_DONE(INSTR_DONE),
        .ENA_ES(ENA_ES), .ENA_CS(ENA_CS), .ENA_SS(ENA_SS), .ENA_DS(ENA_DS),
        .D_SEG(D_SEG), .FLUSH_Q(FLUSH_Q), .INT_INHIBIT(INT_INHIBIT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: a write occupies the cycle after its grant; a locked B owns the bus between writes.
    bit          m_known = 0;
    bit          m_busy, m_hold, m_last_b;
    logic [3:0]  m_ena;
    logic [15:0] m_dseg;
    int          m_icnt;

    logic        s_ra, s_rb, s_flush, s_inh;
    logic [3:0]  s_ena;
    logic [15:0] s_dseg;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input logic va, input logic [1:0] sa, input logic [15:0] da,
                        input logic vb, input logic [1:0] sb, input logic [15:0] db,
                        input logic lk, input logic done);
        bit ga, gb;
        logic [1:0] seg;
        RST = rst; REQA_VALID = va; REQA_SEG = sa; REQA_DATA = da;
        REQB_VALID = vb; REQB_SEG = sb; REQB_DATA = db; REQB_LOCK = lk; INSTR_DONE = done;
        ga = 0; gb = 0;
        if (!m_busy) begin
            if (m_hold) gb = vb;
            else if (va && (!vb || m_last_b)) ga = 1;
            else gb = vb;
        end
        @(negedge CLK);
        s_ra = REQA_READY; s_rb = REQB_READY; s_flush = FLUSH_Q; s_inh = INT_INHIBIT;
        s_ena = {ENA_DS, ENA_SS, ENA_CS, ENA_ES}; s_dseg = D_SEG;
        if (m_known) begin
            check("ready_a", 16'(s_ra), 16'(ga));
            check("ready_b", 16'(s_rb), 16'(gb));
            check("ena", 16'(s_ena), 16'(m_ena));
            check("flush_q", 16'(s_flush), 16'(m_ena[1]));
            check("d_seg", s_dseg, m_dseg);
            check("int_inhibit", 16'(s_inh), 16'(m_icnt != 0));
        end
        if (rst) begin
            m_known = 1; m_busy = 0; m_hold = 0; m_last_b = 1;
            m_ena = '0; m_dseg = '0; m_icnt = 0;
        end else begin
            if (done && !m_ena[2] && m_icnt > 0) m_icnt--;
            if (ga || gb) begin
                seg = ga ? sa : sb;
                m_ena = 4'(1 << seg);
                m_dseg = ga ? da : db;
                m_last_b = gb;
                m_busy = 1;
                if (gb) m_hold = lk;
                if (seg == 2'd2) m_icnt = INH;
            end else begin
                m_ena = '0;
                m_busy = 0;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input logic done);
        step(0, 0, 0, 16'h0, 0, 0, 16'h0, 0, done);
    endtask

    initial begin
        RST = 1; REQA_VALID = 0; REQA_SEG = 0; REQA_DATA = 0;
        REQB_VALID = 0; REQB_SEG = 0; REQB_DATA = 0; REQB_LOCK = 0; INSTR_DONE = 0;
        @(posedge CLK); #1;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("rst_ena", 16'(s_ena), 16'h0);
        check("rst_dseg", s_dseg, 16'h0);
        check("rst_inh", 16'(s_inh), 16'h0);

        // A alone writes DS
        step(0, 1, 2'd3, 16'h1234, 0, 0, 0, 0, 0);
        check("a_only_ready", 16'(s_ra), 16'h1);
        idle(0);
        check("a_only_ena", 16'(s_ena), 16'b1000);
        check("a_only_dseg", s_dseg, 16'h1234);

        // Tie from reset: A first, B two cycles later
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 2'd0, 16'h1111, 1, 2'd3, 16'h2222, 0, 0);
        check("tie_ra", 16'(s_ra), 16'h1);
        check("tie_rb", 16'(s_rb), 16'h0);
        step(0, 0, 0, 0, 1, 2'd3, 16'h2222, 0, 0);
        check("tie_ena_es", 16'(s_ena), 16'b0001);
        check("tie_write_rb", 16'(s_rb), 16'h0);
        step(0, 0, 0, 0, 1, 2'd3, 16'h2222, 0, 0);
        check("tie_rb_late", 16'(s_rb), 16'h1);
        idle(0);
        check("tie_ena_ds", 16'(s_ena), 16'b1000);
        check("tie_dseg", s_dseg, 16'h2222);

        // Locked far load CS then SS while A waits; SS inhibit window
        step(0, 0, 0, 0, 1, 2'd1, 16'hF000, 1, 0);
        check("lk_rb", 16'(s_rb), 16'h1);
        step(0, 1, 2'd0, 16'hAAAA, 1, 2'd2, 16'h0300, 0, 0);
        check("lk_ena_cs", 16'(s_ena), 16'b0010);
        check("lk_flush", 16'(s_flush), 16'h1);
        step(0, 1, 2'd0, 16'hAAAA, 1, 2'd2, 16'h0300, 0, 0);
        check("lk_ra_stall", 16'(s_ra), 16'h0);
        check("lk_rb_locked", 16'(s_rb), 16'h1);
        step(0, 1, 2'd0, 16'hAAAA, 0, 0, 0, 0, 1);
        check("lk_ena_ss", 16'(s_ena), 16'b0100);
        check("ss_inh_on", 16'(s_inh), 16'h1);
        step(0, 1, 2'd0, 16'hAAAA, 0, 0, 0, 0, 1);
        check("ss_inh_held", 16'(s_inh), 16'h1);
        check("lk_ra_free", 16'(s_ra), 16'h1);
        idle(0);
        check("ss_inh_off", 16'(s_inh), 16'h0);
        check("lk_a_dseg", s_dseg, 16'hAAAA);

        // Reset during WRITE aborts cleanly
        step(0, 1, 2'd3, 16'h5555, 0, 0, 0, 0, 0);
        step(1, 1, 2'd3, 16'h5555, 0, 0, 0, 0, 0);
        check("rw_ena_before", 16'(s_ena), 16'b1000);
        step(0, 1, 2'd3, 16'h6666, 0, 0, 0, 0, 0);
        check("rw_ena_none", 16'(s_ena), 16'h0);
        check("rw_dseg", s_dseg, 16'h0);
        check("rw_ra", 16'(s_ra), 16'h1);
        idle(0);
        check("rw_after", 16'(s_ena), 16'b1000);
        check("rw_after_dseg", s_dseg, 16'h6666);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 2) != 0), 2'($urandom), 16'($urandom),
                 ($urandom_range(0, 2) != 0), 2'($urandom), 16'($urandom),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
